lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles in REQ+WAIT before abort (8-bit counter, legal 1..255).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core access request.
REQ-005 req_ready  output  1  lsu accepts request (high only in IDLE, rst low).
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, LSB-justified.
REQ-009 req_ctrl  input  3  000 B, 001 H, 010 W, 011 BU, 100 HU (stores: 000/001/010 only).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores/errors.
REQ-012 resp_err  output  1  access error, valid with resp_valid.
REQ-013 mem_req / mem_gnt  output / input  1 / 1  bus request / grant.
REQ-014 mem_we  output  1  bus write.
REQ-015 mem_addr  output  32  word address, bits[1:0]=00.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_rvalid / mem_rdata  input / input  1 / 32  bus completion (loads and stores) / raw read word.

Function
REQ-019 States IDLE, REQ, WAIT, RESP; request fields latched on accept (req_valid & req_ready) and held to RESP.
REQ-020 IDLE: accept -> RESP if error (REQ-026/027), else REQ; no accept -> stay.
REQ-021 REQ: mem_req=1 with held mem_* fields; mem_gnt & mem_rvalid -> RESP; mem_gnt only -> WAIT; else stay.
REQ-022 WAIT: mem_req=0; mem_rvalid -> RESP capturing mem_rdata.
REQ-023 RESP: resp_valid=1 for exactly one cycle, then IDLE; no back-pressure.
REQ-024 mem_be: B/BU 0001<<addr[1:0]; H/HU 0011<<{addr[1],0}; W 1111; mem_wdata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-025 Load extraction selects byte addr[1:0] / half addr[1] from mem_rdata; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-026 Illegal req_ctrl (101-111, or 011/100 with req_we=1) -> resp_err=1 with no bus access, resp one cycle after accept.
REQ-027 Misaligned access handled per REQ-033/034.
REQ-028 Timeout counter clears on entering REQ, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> RESP, resp_err=1, mem_req dropped; mem_rvalid in same cycle wins (normal completion).
REQ-029 Minimum latency accept->resp_valid: 2 cycles (gnt+rvalid in first REQ cycle); error path: 1 cycle.
REQ-030 mem_rvalid outside REQ/WAIT ignored.

Reset
REQ-031 rst: state IDLE, counter 0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-032 rst mid-access: abandons transaction next edge, no resp_valid for it, mem_req low cycle after rst sampled.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=00 -> resp_err=1, no bus access.
REQ-034 Macro undefined: misaligned low bits ignored (H uses addr[1], W uses 1111), access proceeds normally, resp_err never set by alignment.

Verification
REQ-035 Store SB addr 0x13 wdata 0x000000A5, gnt+rvalid immediately -> mem_addr 0x10, mem_be 1000, mem_wdata 0xA5A5A5A5, resp_valid 2 cycles after accept, resp_err 0.
REQ-036 Load B addr 0x06, mem_rdata 0x00F00000 -> resp_rdata 0xFFFFFFF0; same with BU -> 0x000000F0; HU addr 0x06, mem_rdata 0x8001_0000 -> 0x00008001.
REQ-037 Load W addr 0x02 -> with LSU_MISALIGN_TRAP_EN: resp_err 1, mem_req never high; without: mem_addr 0x00, mem_be 1111, normal data.
REQ-038 TIMEOUT_CYCLES=4, mem_gnt held low -> resp_valid+resp_err after 4 REQ cycles, resp_rdata 0, returns IDLE.
REQ-039 gnt cycle 1, rvalid cycle 3, rst asserted cycle 2 -> no resp_valid, mem_req 0, req_ready 1 first cycle after rst release.
REQ-040 req_ctrl 011 with req_we=1 -> resp_err 1 one cycle after accept, no bus request.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer, accept->resp_valid >= 2 cycles (1 on error), no resp back-pressure.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/HU/W accesses into errors instead of truncating.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b011;
  localparam logic [2:0] CTRL_HU = 3'b100;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  // Request fields that the load extraction still needs after the bus phase.
  typedef struct packed {
    logic       we;
    logic [2:0] ctrl;
    logic [1:0] off;
  } hold_t;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  hold_t       hold_q, hold_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        ctrl_err;
  logic        align_err;
  logic [7:0]  cnt_inc;
  logic [31:0] load_data;

  function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      CTRL_B, CTRL_BU: lane_be = 4'b0001 << off;
      CTRL_H, CTRL_HU: lane_be = 4'b0011 << {off[1], 1'b0};
      default:         lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] ctrl, input logic [31:0] wdata);
    case (ctrl)
      CTRL_B:  lane_wdata = {4{wdata[7:0]}};
      CTRL_H:  lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  ctrl,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (ctrl)
      CTRL_B:  load_extract = {{24{b[7]}}, b};
      CTRL_BU: load_extract = {24'd0, b};
      CTRL_H:  load_extract = {{16{h[15]}}, h};
      CTRL_HU: load_extract = {16'd0, h};
      default: load_extract = rdata;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Unsigned-only encodings have no store form.
  assign ctrl_err = (req_ctrl > CTRL_HU) ||
                    (req_we && ((req_ctrl == CTRL_BU) || (req_ctrl == CTRL_HU)));

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    align_err = 1'b0;
    case (req_ctrl)
      CTRL_H, CTRL_HU: align_err = req_addr[0];
      CTRL_W:          align_err = (req_addr[1:0] != 2'b00);
      default:         align_err = 1'b0;
    endcase
  end
`else
  assign align_err = 1'b0;
`endif

  assign load_data = hold_q.we ? 32'd0 : load_extract(hold_q.ctrl, hold_q.off, mem_rdata);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_inc      = cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          hold_d = '{we: req_we, ctrl: req_ctrl, off: req_addr[1:0]};
          cnt_d  = 8'd0;
          if (ctrl_err || align_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = lane_be(req_ctrl, req_addr[1:0]);
            mem_wdata_d = lane_wdata(req_ctrl, req_wdata);
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        if (mem_gnt && mem_rvalid) begin
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        // A completion arriving on the timeout cycle still counts as a good response.
        if (mem_rvalid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      hold_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small reactive bus model; TIMEOUT_CYCLES set to 4.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Results of the most recent access().
  int          r_lat;
  logic [31:0] r_rd;
  logic        r_err;
  logic        r_saw;
  logic        r_req_at_resp;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic        r_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; the bus grants after gnt_lat REQ cycles and returns
  // rvalid rv_lat cycles after the grant. r_lat counts cycles from the accept edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ctrl, input int gnt_lat, input int rv_lat,
                        input logic [31:0] rdata);
    int rq;
    int since;
    bit granted;
    bit done;
    rq = 0; since = 0; granted = 0; done = 0;
    r_lat = 0; r_rd = 32'hDEADDEAD; r_err = 1'b0; r_saw = 1'b0; r_req_at_resp = 1'b1;
    r_addr = 32'd0; r_be = 4'd0; r_wd = 32'd0; r_we = 1'b0;
    for (int w = 0; w < 10 && !req_ready; w++) cyc();
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
    cyc();
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (resp_valid) begin
        r_lat = k; r_rd = resp_rdata; r_err = resp_err; r_req_at_resp = mem_req;
        done = 1;
      end else begin
        if (mem_req) begin
          r_saw = 1'b1; r_addr = mem_addr; r_be = mem_be; r_wd = mem_wdata; r_we = mem_we;
          if (rq == gnt_lat) begin
            mem_gnt = 1'b1; granted = 1; since = 0;
          end
          rq++;
        end
        if (granted) begin
          if (since == rv_lat) begin
            mem_rvalid = 1'b1; mem_rdata = rdata; granted = 0;
          end
          since++;
        end
        cyc();
      end
    end
  endtask

  task automatic post_check(input string tag);
    cyc();
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_ctrl = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    cyc(); cyc();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    // SB 0x13, immediate gnt+rvalid
    access(1'b1, 32'h13, 32'h000000A5, 3'b000, 0, 0, 32'd0);
    check("sb_lat", r_lat, 32'd2);
    check("sb_addr", r_addr, 32'h10);
    check("sb_be", 32'(r_be), 32'h8);
    check("sb_wdata", r_wd, 32'hA5A5A5A5);
    check("sb_we", 32'(r_we), 32'd1);
    check("sb_err", 32'(r_err), 32'd0);
    check("sb_rdata", r_rd, 32'd0);
    post_check("sb");

    // LB 0x06 through WAIT; rvalid lands on the timeout cycle and wins
    access(1'b0, 32'h06, 32'd0, 3'b000, 1, 2, 32'h00F00000);
    check("lb_lat", r_lat, 32'd5);
    check("lb_err", 32'(r_err), 32'd0);
    check("lb_rdata", r_rd, 32'hFFFFFFF0);
    check("lb_be", 32'(r_be), 32'h4);
    check("lb_addr", r_addr, 32'h04);
    check("lb_we", 32'(r_we), 32'd0);
    post_check("lb");

    access(1'b0, 32'h06, 32'd0, 3'b011, 0, 0, 32'h00F00000);
    check("lbu_lat", r_lat, 32'd2);
    check("lbu_rdata", r_rd, 32'h000000F0);

    access(1'b0, 32'h06, 32'd0, 3'b100, 0, 1, 32'h80010000);
    check("lhu_lat", r_lat, 32'd3);
    check("lhu_rdata", r_rd, 32'h00008001);
    check("lhu_be", 32'(r_be), 32'hC);

    access(1'b0, 32'h02, 32'd0, 3'b001, 0, 0, 32'h80010000);
    check("lh_rdata", r_rd, 32'hFFFF8001);

    access(1'b0, 32'h01, 32'd0, 3'b000, 0, 0, 32'h00007F00);
    check("lb_pos_rdata", r_rd, 32'h0000007F);
    check("lb_pos_be", 32'(r_be), 32'h2);

    access(1'b1, 32'h00, 32'h1234ABCD, 3'b001, 0, 0, 32'd0);
    check("sh_be", 32'(r_be), 32'h3);
    check("sh_wdata", r_wd, 32'hABCDABCD);

    access(1'b1, 32'h08, 32'hDEADBEEF, 3'b010, 0, 0, 32'd0);
    check("sw_be", 32'(r_be), 32'hF);
    check("sw_wdata", r_wd, 32'hDEADBEEF);
    check("sw_addr", r_addr, 32'h08);

    access(1'b0, 32'h0C, 32'd0, 3'b010, 0, 0, 32'h12345678);
    check("lw_rdata", r_rd, 32'h12345678);

    // Misaligned word and half loads
    access(1'b0, 32'h02, 32'd0, 3'b010, 0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_w_lat", r_lat, 32'd1);
    check("mis_w_err", 32'(r_err), 32'd1);
    check("mis_w_nobus", 32'(r_saw), 32'd0);
    check("mis_w_rdata", r_rd, 32'd0);
`else
    check("mis_w_lat", r_lat, 32'd2);
    check("mis_w_err", 32'(r_err), 32'd0);
    check("mis_w_addr", r_addr, 32'h00);
    check("mis_w_be", 32'(r_be), 32'hF);
    check("mis_w_rdata", r_rd, 32'hCAFEF00D);
`endif
    access(1'b0, 32'h03, 32'd0, 3'b100, 0, 0, 32'hBEEF0000);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_h_err", 32'(r_err), 32'd1);
    check("mis_h_nobus", 32'(r_saw), 32'd0);
`else
    check("mis_h_err", 32'(r_err), 32'd0);
    check("mis_h_be", 32'(r_be), 32'hC);
    check("mis_h_rdata", r_rd, 32'h0000BEEF);
`endif

    // Timeout with grant never given
    access(1'b0, 32'h40, 32'd0, 3'b010, 99, 0, 32'd0);
    check("to_req_lat", r_lat, 32'd5);
    check("to_req_err", 32'(r_err), 32'd1);
    check("to_req_rdata", r_rd, 32'd0);
    check("to_req_memreq", 32'(r_req_at_resp), 32'd0);
    check("to_req_saw", 32'(r_saw), 32'd1);
    post_check("to_req");

    // Timeout in WAIT
    access(1'b0, 32'h44, 32'd0, 3'b010, 0, 99, 32'd0);
    check("to_wait_lat", r_lat, 32'd5);
    check("to_wait_err", 32'(r_err), 32'd1);

    // Illegal encodings
    access(1'b1, 32'h20, 32'h11, 3'b011, 0, 0, 32'd0);
    check("ill_sbu_lat", r_lat, 32'd1);
    check("ill_sbu_err", 32'(r_err), 32'd1);
    check("ill_sbu_nobus", 32'(r_saw), 32'd0);
    post_check("ill_sbu");
    access(1'b0, 32'h20, 32'd0, 3'b101, 0, 0, 32'd0);
    check("ill_101_err", 32'(r_err), 32'd1);
    check("ill_101_rdata", r_rd, 32'd0);
    access(1'b1, 32'h20, 32'd0, 3'b100, 0, 0, 32'd0);
    check("ill_shu_err", 32'(r_err), 32'd1);
    check("ill_shu_nobus", 32'(r_saw), 32'd0);

    // rvalid while idle is ignored
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    cyc(); cyc();
    mem_rvalid = 1'b0;
    check("idle_rvalid_resp", 32'(resp_valid), 32'd0);
    check("idle_rvalid_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h24; req_wdata = 32'h55AA55AA; req_ctrl = 3'b010;
    cyc();
    req_valid = 1'b0;
    check("mid_memreq", 32'(mem_req), 32'd1);
    check("mid_addr", mem_addr, 32'h24);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    rst = 1'b1;
    cyc();
    check("mid_rst_memreq", 32'(mem_req), 32'd0);
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_be", 32'(mem_be), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    #1;
    check("mid_rel_ready", 32'(req_ready), 32'd1);
    cyc();
    mem_rvalid = 1'b0;
    check("mid_late_resp", 32'(resp_valid), 32'd0);
    check("mid_late_ready", 32'(req_ready), 32'd1);
    cyc();
    check("mid_late_resp2", 32'(resp_valid), 32'd0);

    access(1'b0, 32'h0C, 32'd0, 3'b010, 0, 0, 32'h0BADF00D);
    check("recover_lat", r_lat, 32'd2);
    check("recover_rdata", r_rd, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
